// File: rtl/demux_pkg.sv
// Shared definitions for the registered 1-to-N stream demultiplexer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: mode encoding, channel slot state type, beat counter width.
package demux_pkg;

    // in_mode encoding
    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_RR   = 1'b1;

    // accepted-beat counter width
    localparam int BEAT_CNT_W = 16;

    // per-channel holding register state
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demux_chan_slot.sv
// One output channel slot: a one-entry holding register with valid/ready drain.
// Latency: a write lands on o_valid/o_data after the next clk edge.
// Backpressure: o_free is high when empty, or full and draining this cycle.
// Ports: clk, rst (async active-high), i_wr/i_data (write from the steering
//        logic), i_ready (consumer ready), o_valid/o_data (registered channel
//        output), o_free (slot can take a write this cycle).
module demux_chan_slot
    import demux_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_wr,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_free
);

    slot_state_t  r_state;
    slot_state_t  w_state_nxt;
    logic [W-1:0] r_data;

    // A write wins over a drain: draining and refilling in the same cycle
    // keeps the slot FULL with the new beat.
    always_comb begin
        w_state_nxt = r_state;
        if (i_wr) begin
            w_state_nxt = FULL;
        end else if ((r_state == FULL) && i_ready) begin
            w_state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (i_wr) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = (r_state == FULL);
    assign o_data  = r_data;
    assign o_free  = (r_state == EMPTY) || i_ready;

endmodule

// File: rtl/demux_stream_1ton.sv
// Registered 1-to-N stream demultiplexer, addressed or round-robin steering.
// Latency: 1 cycle from input accept to the target channel's out_valid/out_data.
// Backpressure: in_ready follows the target slot's free state (all slots when
//               broadcasting); a stalled channel only blocks beats aimed at it.
// Ports: clk, rst (async active-high); in_valid/in_ready/in_data input stream;
//        in_sel target in addressed mode; in_mode (0 addressed, 1 round-robin);
//        in_bcast (only when DEMUX_BCAST_EN is defined); out_valid/out_ready/
//        out_data per-channel streams (channel k at [k*W +: W]); rr_ptr next
//        round-robin target; beat_cnt accepted beats (wraps).
// Build option: DEMUX_BCAST_EN adds in_bcast to write every slot at once.
module demux_stream_1ton
    import demux_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          in_data,
    input  logic [SW-1:0]         in_sel,
    input  logic                  in_mode,
`ifdef DEMUX_BCAST_EN
    input  logic                  in_bcast,
`endif
    output logic [N-1:0]          out_valid,
    input  logic [N-1:0]          out_ready,
    output logic [N*W-1:0]        out_data,
    output logic [SW-1:0]         rr_ptr,
    output logic [BEAT_CNT_W-1:0] beat_cnt
);

    logic [SW-1:0]         r_rr_ptr;
    logic [BEAT_CNT_W-1:0] r_beat_cnt;
    logic [SW-1:0]         w_tgt;
    logic [N-1:0]          w_free;
    logic [N-1:0]          w_wr;
    logic                  w_bcast;
    logic                  w_tgt_free;
    logic                  w_accept;

`ifdef DEMUX_BCAST_EN
    assign w_bcast = in_bcast;
`else
    assign w_bcast = 1'b0;
`endif

    // in_sel is ignored in round-robin mode
    assign w_tgt      = (in_mode == MODE_RR) ? r_rr_ptr : in_sel;
    assign w_tgt_free = w_bcast ? (&w_free) : w_free[w_tgt];
    assign in_ready   = w_tgt_free && !rst;
    assign w_accept   = in_valid && in_ready;

    for (genvar k = 0; k < N; k++) begin : g_slot
        assign w_wr[k] = w_accept && (w_bcast || (w_tgt == SW'(k)));

        demux_chan_slot #(
            .W (W)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .i_wr    (w_wr[k]),
            .i_data  (in_data),
            .i_ready (out_ready[k]),
            .o_valid (out_valid[k]),
            .o_data  (out_data[k*W +: W]),
            .o_free  (w_free[k])
        );
    end

    // N is a power of two, so the pointer wraps N-1 -> 0 by natural overflow.
    // A broadcast does not advance the pointer even in round-robin mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            if ((in_mode == MODE_RR) && !w_bcast) begin
                r_rr_ptr <= r_rr_ptr + 1'b1;
            end
        end
    end

    assign rr_ptr   = r_rr_ptr;
    assign beat_cnt = r_beat_cnt;

endmodule

// File: tb/tb_demux_stream_1ton.sv
module tb_demux_stream_1ton;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic           clk      = 1'b0;
    logic           rst      = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_mode  = 1'b0;
    logic           in_bcast = 1'b0;
    logic [W-1:0]   in_data  = '0;
    logic [SW-1:0]  in_sel   = '0;
    logic [N-1:0]   out_ready = '0;
    logic           in_ready;
    logic [N-1:0]   out_valid;
    logic [N*W-1:0] out_data;
    logic [SW-1:0]  rr_ptr;
    logic [15:0]    beat_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    demux_stream_1ton #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_mode   (in_mode),
`ifdef DEMUX_BCAST_EN
        .in_bcast  (in_bcast),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rr_ptr    (rr_ptr),
        .beat_cnt  (beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ch(input int k);
        return out_data[k*W +: W];
    endfunction

    // ---------------- behavioural model ----------------
    // Each channel is a one-deep mailbox; the model tracks what each mailbox
    // holds, the round-robin pointer and the number of accepted beats.
    logic         m_v [N] = '{default: 1'b0};
    logic [W-1:0] m_d [N] = '{default: '0};
    int           m_rr  = 0;
    int           m_cnt = 0;
    logic         m_acc;
    int           m_t;

    function automatic logic m_in_ready();
        int t;
        logic ok;
        if (rst) return 1'b0;
        if (in_bcast) begin
            ok = 1'b1;
            for (int k = 0; k < N; k++) ok = ok && (!m_v[k] || out_ready[k]);
            return ok;
        end
        t = in_mode ? m_rr : int'(in_sel);
        return !m_v[t] || out_ready[t];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                m_v[k] = 1'b0;
                m_d[k] = '0;
            end
            m_rr  = 0;
            m_cnt = 0;
        end else begin
            m_acc = in_valid && m_in_ready();
            m_t   = in_mode ? m_rr : int'(in_sel);
            for (int k = 0; k < N; k++) begin
                if (m_acc && (in_bcast || k == m_t)) begin
                    m_v[k] = 1'b1;
                    m_d[k] = in_data;
                end else if (m_v[k] && out_ready[k]) begin
                    m_v[k] = 1'b0;
                end
            end
            if (m_acc) begin
                m_cnt = (m_cnt + 1) % 65536;
                if (in_mode && !in_bcast) m_rr = (m_rr + 1) % N;
            end
        end
    end

    // per-cycle comparison on the falling edge
    always @(negedge clk) begin
        logic [N-1:0]   ev;
        logic [N*W-1:0] ed;
        for (int k = 0; k < N; k++) begin
            ev[k]       = m_v[k];
            ed[k*W +: W] = m_d[k];
        end
        chk("cyc_out_valid", 64'(out_valid), 64'(ev));
        chk("cyc_out_data",  64'(out_data),  64'(ed));
        chk("cyc_rr_ptr",    64'(rr_ptr),    64'(m_rr));
        chk("cyc_beat_cnt",  64'(beat_cnt),  64'(m_cnt));
        chk("cyc_in_ready",  64'(in_ready),  64'(m_in_ready()));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        // reset
        step();
        step();
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_data",  64'(out_data),  64'h0);
        chk("rst_rr_ptr",    64'(rr_ptr),    64'h0);
        chk("rst_beat_cnt",  64'(beat_cnt),  64'h0);
        chk("rst_in_ready",  64'(in_ready),  64'h0);
        rst = 1'b0;
        step();

        // addressed beat to channel 2
        out_ready = 4'b1111;
        in_mode = 1'b0; in_sel = 2'd2; in_data = 8'hA5; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t1_out_valid", 64'(out_valid), 64'h4);
        chk("t1_ch2",       64'(ch(2)),     64'hA5);
        chk("t1_beat_cnt",  64'(beat_cnt),  64'd1);
        step();

        // addressed, channel 1 stalled
        out_ready = 4'b1101;
        in_sel = 2'd1; in_data = 8'h11; in_valid = 1'b1;
        step();
        in_data = 8'h22;
        #1;
        chk("t2_blocked",   64'(in_ready),  64'h0);
        chk("t2_ch1_first", 64'(ch(1)),     64'h11);
        step();
        step();
        chk("t2_cnt_hold",  64'(beat_cnt),  64'd2);
        out_ready = 4'b1111;
        #1;
        chk("t2_unblocked", 64'(in_ready),  64'h1);
        step();
        in_valid = 1'b0;
        chk("t2_ch1_second", 64'(ch(1)),    64'h22);
        chk("t2_out_valid",  64'(out_valid), 64'h2);
        chk("t2_beat_cnt",   64'(beat_cnt), 64'd3);
        step();

        // round-robin, six back-to-back beats
        in_mode = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = 8'(i);
            step();
            chk("t3_onehot", 64'(out_valid), 64'(1 << (i % 4)));
            chk("t3_data",   64'(ch(i % 4)), 64'(i));
        end
        in_valid = 1'b0;
        chk("t3_rr_ptr",   64'(rr_ptr),   64'd2);
        chk("t3_beat_cnt", 64'(beat_cnt), 64'd9);
        step();

        // round-robin blocked on stalled channel 1
        out_ready = 4'b1101;
        in_mode = 1'b0; in_sel = 2'd1; in_data = 8'h77; in_valid = 1'b1;
        step();
        in_mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'h40 + 8'(i);
            step();
        end
        in_data = 8'h43;
        #1;
        chk("t4_blocked",  64'(in_ready), 64'h0);
        chk("t4_rr_hold",  64'(rr_ptr),   64'd1);
        step();
        step();
        chk("t4_rr_still", 64'(rr_ptr),    64'd1);
        chk("t4_no_skip",  64'(out_valid), 64'h2);
        chk("t4_cnt",      64'(beat_cnt),  64'd13);
        out_ready = 4'b1111;
        step();
        in_valid = 1'b0;
        chk("t4_ch1",      64'(ch(1)),    64'h43);
        chk("t4_rr_next",  64'(rr_ptr),   64'd2);
        chk("t4_cnt_next", 64'(beat_cnt), 64'd14);
        step();

        // asynchronous reset with channels 0 and 3 full
        out_ready = 4'b0000;
        in_mode = 1'b0; in_sel = 2'd0; in_data = 8'hC0; in_valid = 1'b1;
        step();
        in_sel = 2'd3; in_data = 8'hC3;
        step();
        in_valid = 1'b0;
        chk("t5_full",     64'(out_valid), 64'h9);
        chk("t5_cnt_pre",  64'(beat_cnt),  64'd16);
        rst = 1'b1;
        #1;
        chk("t5_valid_clr", 64'(out_valid), 64'h0);
        chk("t5_rr_clr",    64'(rr_ptr),    64'h0);
        chk("t5_cnt_clr",   64'(beat_cnt),  64'h0);
        chk("t5_rdy_clr",   64'(in_ready),  64'h0);
        step();
        rst = 1'b0;
        step();

`ifdef DEMUX_BCAST_EN
        // broadcast waits for every slot to be free
        in_mode = 1'b0; in_sel = 2'd2; in_data = 8'h99; in_valid = 1'b1;
        step();
        in_mode = 1'b1; in_bcast = 1'b1; in_data = 8'h3C; out_ready = 4'b1011;
        #1;
        chk("t6_blocked", 64'(in_ready), 64'h0);
        step();
        chk("t6_cnt_hold", 64'(beat_cnt), 64'd1);
        out_ready = 4'b1111;
        #1;
        chk("t6_unblocked", 64'(in_ready), 64'h1);
        step();
        in_valid = 1'b0; in_bcast = 1'b0;
        chk("t6_all_valid", 64'(out_valid), 64'hF);
        chk("t6_all_data",  64'(out_data),  64'h3C3C3C3C);
        chk("t6_cnt",       64'(beat_cnt),  64'd2);
        chk("t6_rr",        64'(rr_ptr),    64'd0);
        step();
`endif

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
